// File: rtl/lpc_lattice_synth.sv
// All-pole lattice synthesis filter, one stage per clock, Q1.31 reflection coefficients.
// Optional feature: define LPC_LATTICE_SAT_EN to saturate f'/b_m instead of wrapping.
`default_nettype none

module lpc_lattice_synth #(
  parameter int ORDER  = 10,
  parameter int DATA_W = 16,
  parameter int K_W    = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             k_wr,
  input  logic [$clog2(ORDER+1)-1:0]       k_addr,
  input  logic signed [K_W-1:0]            k_data,
  input  logic                             state_clr,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DATA_W-1:0]         in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [DATA_W-1:0]         out_data
);

  localparam int AW  = $clog2(ORDER+1);
  localparam int P_W = DATA_W + K_W;
  localparam int S_W = DATA_W + 2;
  localparam logic signed [P_W-1:0] RND_HALF = P_W'(1) <<< (K_W-2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [K_W-1:0]    k_reg [1:ORDER];
  logic signed [DATA_W-1:0] b_reg [0:ORDER-1];
  logic signed [DATA_W-1:0] f_reg;
  logic [AW-1:0]            m;

  logic signed [K_W-1:0]    k_cur;
  logic signed [DATA_W-1:0] b_prev, f_new, b_new;
  logic signed [P_W-1:0]    rnd_f, rnd_b;
  logic signed [S_W-1:0]    sum_f, sum_b;
  logic                     accept;

  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [S_W-1:0] s);
`ifdef LPC_LATTICE_SAT_EN
    logic signed [S_W-1:0] s_max, s_min;
    s_max = S_W'((1 <<< (DATA_W-1)) - 1);
    s_min = -S_W'(1 <<< (DATA_W-1));
    if (s > s_max)      return s_max[DATA_W-1:0];
    else if (s < s_min) return s_min[DATA_W-1:0];
    else                return DATA_W'(s);
`else
    return DATA_W'(s);
`endif
  endfunction

  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == OUT);
  assign accept    = in_valid && in_ready;

  // One lattice stage: forward path first, then the backward path uses the fresh f'.
  always_comb begin
    k_cur  = k_reg[m];
    b_prev = b_reg[m - AW'(1)];
    rnd_f  = (P_W'(k_cur) * P_W'(b_prev) + RND_HALF) >>> (K_W-1);
    sum_f  = S_W'(f_reg) - S_W'(rnd_f);
    f_new  = reduce(sum_f);
    rnd_b  = (P_W'(k_cur) * P_W'(f_new) + RND_HALF) >>> (K_W-1);
    sum_b  = S_W'(b_prev) + S_W'(rnd_b);
    b_new  = reduce(sum_b);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (m == AW'(1)) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i <= ORDER; i++) k_reg[i] <= '0;
      for (int i = 0; i < ORDER; i++)  b_reg[i] <= '0;
      f_reg    <= '0;
      m        <= '0;
      out_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (k_wr && (k_addr != '0) && (k_addr <= AW'(ORDER)))
            k_reg[k_addr] <= k_data;
          if (state_clr)
            for (int i = 0; i < ORDER; i++) b_reg[i] <= '0;
          if (accept) begin
            f_reg <= in_data;
            m     <= AW'(ORDER);
          end
        end
        RUN: begin
          f_reg <= f_new;
          m     <= m - AW'(1);
          // b_ORDER feeds no later stage, so it is never stored.
          if (m < AW'(ORDER)) b_reg[m] <= b_new;
          if (m == AW'(1)) begin
            b_reg[0] <= f_new;
            out_data <= f_new;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lpc_lattice_synth.sv
// Scoreboard bench for lpc_lattice_synth: expected samples queued at drive time, popped on output.
`default_nettype none

module tb_lpc_lattice_synth;

  localparam int ORDER  = 10;
  localparam int DATA_W = 16;
  localparam int K_W    = 32;
  localparam int AW     = $clog2(ORDER+1);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     k_wr;
  logic [AW-1:0]            k_addr;
  logic signed [K_W-1:0]    k_data;
  logic                     state_clr;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;

  lpc_lattice_synth #(.ORDER(ORDER), .DATA_W(DATA_W), .K_W(K_W)) dut (
    .clk(clk), .rst_n(rst_n), .k_wr(k_wr), .k_addr(k_addr), .k_data(k_data),
    .state_clr(state_clr), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int mk [1:ORDER];
  int mb [0:ORDER-1];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check("idle_timeout", 0, 1);
  endtask

  task automatic wr_k(input int addr, input int val);
    wait_idle();
    k_wr = 1'b1; k_addr = AW'(addr); k_data = val;
    tick();
    k_wr = 1'b0;
  endtask

  task automatic clr_state();
    wait_idle();
    state_clr = 1'b1;
    tick();
    state_clr = 1'b0;
  endtask

  // Accept one sample, queue its expected output, and measure handshake-to-out_valid latency.
  task automatic send(input int e, input int expv);
    int n;
    wait_idle();
    in_valid = 1'b1; in_data = DATA_W'(e);
    exp_q.push_back(expv);
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check("latency", n, ORDER + 1);
  endtask

  function automatic longint red(input longint s);
`ifdef LPC_LATTICE_SAT_EN
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
`else
    return longint'(shortint'(s));
`endif
  endfunction

  function automatic int model_step(input int e);
    longint f, p, r, bn;
    f = e;
    for (int m = ORDER; m >= 1; m--) begin
      p  = longint'(mk[m]) * longint'(mb[m-1]);
      r  = (p + 64'sd1073741824) >>> 31;
      f  = red(f - r);
      p  = longint'(mk[m]) * f;
      r  = (p + 64'sd1073741824) >>> 31;
      bn = red(longint'(mb[m-1]) + r);
      if (m < ORDER) mb[m] = int'(bn);
    end
    mb[0] = int'(f);
    return int'(f);
  endfunction

  // Output transfers happen at the next rising edge when both handshake signals are high here.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", out_data, 0);
        else check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e, kv;
    rst_n = 1'b0; k_wr = 1'b0; k_addr = '0; k_data = '0; state_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Zero coefficients pass the excitation straight through.
    send(100, 100);
    send(-7, -7);
    send(32767, 32767);

    // Single-pole impulse response with k_1 = 0.5.
    clr_state();
    wr_k(1, 32'sh40000000);
    send(1000, 1000);
    send(0, -500);
    send(0, 250);
    send(0, -125);
    send(0, 62);
    send(0, -31);
    clr_state();
    send(0, 0);

    // k_1 = -1.0 drives the second sample out of range.
    clr_state();
    wr_k(1, 32'sh80000000);
    send(20000, 20000);
`ifdef LPC_LATTICE_SAT_EN
    send(20000, 32767);
`else
    send(20000, -25536);
`endif

    // Back-pressure in OUT; a coefficient write there must be dropped.
    clr_state();
    wr_k(1, 32'sh40000000);
    out_ready = 1'b0;
    send(1000, 1000);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 1000);
      check("stall_in_ready", in_ready, 0);
      k_wr = (i == 1); k_addr = AW'(1); k_data = '0;
      tick();
      k_wr = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    send(0, -500);

    // Reset in the middle of a sample; that sample is lost and k returns to zero.
    wait_idle();
    in_valid = 1'b1; in_data = 16'sd123;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready_after", in_ready, 1);
    send(50, 50);

    // Random coefficients and excitation against the reference model.
    clr_state();
    for (int i = 0; i < ORDER; i++) mb[i] = 0;
    for (int i = 1; i <= ORDER; i++) begin
      kv = int'($urandom_range(32'h66666666)) - 32'sh33333333;
      mk[i] = kv;
      wr_k(i, kv);
    end
    for (int i = 0; i < 20; i++) begin
      e = int'($urandom_range(16000)) - 8000;
      send(e, model_step(e));
    end

    tick(); tick();
    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
